ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
//  Consumes the ID/EX funct field {funct7,funct3} and both register operands.
//  Holds the pipeline via stall_o for the duration of the operation.
//  Delivers one 32-bit result toward the EX/MEM register.
// PARAMETERS
//  XLEN      32  operand/result width; iteration count equals XLEN
// PORTS
//  clk_i       in   1     clock; all state changes on posedge
//  rst_i       in   1     synchronous, active-high reset
//  req_i       in   1     ID/EX holds a valid R-type instruction (opcode 0110011)
//  funct_i     in   10    {funct7[6:0],funct3[2:0]} from ID/EX
//  rs1_data_i  in   32    forwarded rs1 operand (dividend / multiplicand)
//  rs2_data_i  in   32    forwarded rs2 operand (divisor / multiplier)
//  stall_o     out  1     hold PC, IF/ID, ID/EX; insert no bubble in EX/MEM
//  done_o      out  1     result_o valid this cycle (one-cycle pulse)
//  result_o    out  32    MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result
// BEHAVIOUR
//  - Accept: req_i=1 && funct_i[9:3]==7'b0000001, state IDLE; other funct7 ignored, stall_o=0.
//  - States: IDLE -> RUN -> DONE -> IDLE; special-case path IDLE -> DONE.
//  - IDLE accept cycle: latch op=funct_i[2:0]; latch |rs1|,|rs2| per signedness (MULH/DIV/REM both
//    signed, MULHSU rs1 signed only, others unsigned); latch result sign; cnt<=0.
//  - RUN: one shift-add (mul) or restoring subtract-shift (div) step per cycle; cnt 0..XLEN-1;
//    at cnt==XLEN-1 go DONE. Operand inputs ignored during RUN (latched copies used).
//  - DONE: done_o=1, stall_o=0, result_o = sign-corrected selection; pipeline advances on this
//    edge; req_i still high this cycle MUST NOT restart; next state IDLE.
//  - Timing normal path: stall_o=1 for 1+XLEN=33 cycles, done_o in cycle 34 after accept.
//  - stall_o = !rst_i && ((IDLE && accept) || RUN). Combinational from state/inputs.
//  - Result select: MUL low 32 of product; MULH/MULHSU/MULHU high 32 of 64-bit product
//    (64-bit two's-complement negate when sign set); DIV/DIVU quotient; REM/REMU remainder.
//  - Sign rules: quotient negative iff signs differ; remainder takes dividend sign.
//  - Special cases, detected in IDLE, go straight to DONE (stall 1 cycle, done next cycle):
//      divisor==0: DIV/DIVU -> 32'hFFFF_FFFF, REM/REMU -> rs1.
//      DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM same operands -> 0.
//  - Back-to-back M-ops: second op accepted in the IDLE cycle right after DONE.
//  - Reset (any state, incl. mid-RUN): state IDLE, cnt 0, accumulators 0, result_o 0,
//    done_o 0, stall_o 0 during reset cycle; op in flight is discarded.
//  - result_o holds its last value outside DONE; only done_o qualifies it.
// STRUCTURE
//  - Shared package: M-ext funct7 constant 7'b0000001; funct3 codes MUL=000 MULH=001 MULHSU=010
//    MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111; 2-bit state encoding IDLE/RUN/DONE.
//  - One sub-module muldiv_datapath: 64-bit acc/shift regs, per-cycle add/subtract step;
//    top level holds FSM, counter, operand sign handling and result mux.
//  - Hazard unit ORs stall_o into its existing stall; EX/MEM muxes result_o when M-op.
// TESTING
//  - MUL 7 x -3: stall_o high 33 cycles, done_o 1 cycle, result_o=32'hFFFF_FFEB.
//  - MULHU FFFF_FFFF x FFFF_FFFF -> FFFF_FFFE; MULH 8000_0000 x 8000_0000 -> 4000_0000;
//    MULHSU FFFF_FFFF x 2 -> FFFF_FFFF.
//  - DIV -7/2 -> FFFF_FFFD, REM -7/2 -> FFFF_FFFF, DIVU 100/7 -> 14, REMU 100/7 -> 2.
//  - DIV x/0 -> FFFF_FFFF and REM 5/0 -> 5 with 1 stall cycle; DIV 8000_0000/-1 -> 8000_0000.
//  - req_i held through DONE, then new DIVU next cycle: exactly two done_o pulses, no re-execute.
//  - rst_i asserted at cnt==10: next cycle IDLE, stall_o=0, done_o never pulses; new MUL ok.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
// Holds the M-extension funct7, funct3 op codes and the FSM state encoding.
package ex_muldiv_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// Shared 2*W accumulator: shift-add multiply or restoring divide, one step per cycle.
// Ports: load_i/step_i/is_div_i control, a_i/b_i magnitudes, acc_o = {hi,lo}.
module muldiv_datapath #(
  parameter int unsigned W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W:0]     sum;
  logic [W:0]     tmp;
  logic [W:0]     diff;

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    // mul: hi += opb when lo[0], then shift right with carry in
    sum  = {1'b0, acc_q[2*W-1:W]}
         + (acc_q[0] ? {1'b0, opb_q} : '0);
    // div: shift next dividend bit into the remainder
    tmp  = {acc_q[2*W-1:W], acc_q[W-1]};
    diff = tmp - {1'b0, opb_q};
    if (load_i) begin
      acc_d = {{W{1'b0}}, a_i};
      opb_d = b_i;
    end else if (step_i) begin
      if (!is_div_i) begin
        acc_d = {sum, acc_q[W-1:1]};
      end else if (!diff[W]) begin
        acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {tmp[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: FSM, operand sign handling and result select.
// Ports: req/funct/rs1/rs2 from ID/EX; stall_o to hazard unit; done_o/result_o to EX/MEM.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   sval_q, sval_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept, a_sgn, b_sgn, sa, sb;
  logic              div0, ovf;
  logic [2:0]        f3;
  logic [XLEN-1:0]   a_abs, b_abs, sel;
  logic [XLEN-1:0]   lo, hi;
  logic [2*XLEN-1:0] acc, acc_neg;
  logic              load, step;

  muldiv_datapath #(.W(XLEN)) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (op_q[2]),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .acc_o    (acc)
  );

  always_comb begin
    f3     = funct_i[2:0];
    accept = req_i && (funct_i[9:3] == FUNCT7_M);
    a_sgn  = (f3 == F3_MULH) || (f3 == F3_MULHSU)
          || (f3 == F3_DIV)  || (f3 == F3_REM);
    b_sgn  = (f3 == F3_MULH) || (f3 == F3_DIV)
          || (f3 == F3_REM);
    sa     = a_sgn && rs1_data_i[XLEN-1];
    sb     = b_sgn && rs2_data_i[XLEN-1];
    a_abs  = sa ? -rs1_data_i : rs1_data_i;
    b_abs  = sb ? -rs2_data_i : rs2_data_i;
    div0   = f3[2] && (rs2_data_i == '0);
    ovf    = ((f3 == F3_DIV) || (f3 == F3_REM))
          && (rs1_data_i == MIN_NEG)
          && (rs2_data_i == '1);
  end

  always_comb begin
    acc_neg = -acc;
    lo      = acc[XLEN-1:0];
    hi      = neg_q ? acc_neg[2*XLEN-1:XLEN]
                    : acc[2*XLEN-1:XLEN];
    sel     = '0;
    unique case (op_q)
      F3_MUL:    sel = lo;
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  sel = hi;
      F3_DIV,
      F3_DIVU:   sel = neg_q ? -lo : lo;
      default:   sel = neg_q ? -acc[2*XLEN-1:XLEN]
                             : acc[2*XLEN-1:XLEN];
    endcase
    if (spec_q) sel = sval_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    sval_d   = sval_q;
    res_d    = res_q;
    load     = 1'b0;
    step     = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    result_o = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          op_d    = f3;
          // remainder follows the dividend sign only
          neg_d   = (f3[2] && f3[1]) ? sa : (sa ^ sb);
          cnt_d   = '0;
          if (div0 || ovf) begin
            spec_d  = 1'b1;
            sval_d  = div0 ? (f3[1] ? rs1_data_i : '1)
                           : (f3[1] ? '0 : MIN_NEG);
            state_d = ST_DONE;
          end else begin
            spec_d  = 1'b0;
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        stall_o = 1'b1;
        step    = 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_o   = 1'b1;
        result_o = sel;
        res_d    = sel;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      load     = 1'b0;
      step     = 1'b0;
      stall_o  = 1'b0;
      done_o   = 1'b0;
      result_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      sval_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      sval_q  <= sval_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit.
// Checks results, stall lengths, done pulses and mid-operation reset.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [9:0]  funct_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  ex_muldiv_unit dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .funct_i    (funct_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Leaves req_i high through the done cycle; returns #1 after negedge of that cycle.
  task automatic do_op(input string tag,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp_res,
                       input int exp_stall);
    int stalls;
    bit got;
    logic [31:0] res;
    stalls = 0;
    got = 1'b0;
    res = '0;
    @(negedge clk_i);
    req_i = 1'b1;
    funct_i = {7'b0000001, f3};
    rs1_data_i = a;
    rs2_data_i = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done_o) begin
        got = 1'b1;
        res = result_o;
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk_i);
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_idle_done"}, 32'(done_o), 32'd0);
  endtask

  int d0;

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // non-M funct7 must be ignored
    req_i = 1'b1;
    funct_i = {7'b0000000, 3'b000};
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd4;
    d0 = done_cnt;
    repeat (3) begin
      #1;
      chk("nonm_stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
    end
    chk("nonm_done", 32'(done_cnt - d0), 32'd0);
    req_i = 1'b0;

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    idle_chk("mul");
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    idle_chk("mulhu");
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    idle_chk("mulh");
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    idle_chk("mulhsu");
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    idle_chk("div");
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    idle_chk("rem");
    do_op("div_nd", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    idle_chk("div_nd");
    do_op("rem_nd", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    idle_chk("rem_nd");
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    idle_chk("divu");
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    idle_chk("remu");
    do_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    idle_chk("div0");
    do_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    idle_chk("rem0");
    do_op("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    idle_chk("divu0");
    do_op("ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    idle_chk("ovf");
    do_op("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    idle_chk("ovf_rem");

    // req held through DONE, then a second DIVU right after
    d0 = done_cnt;
    do_op("b2b1", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("b2b2", 3'b101, 32'd50, 32'd5, 32'd10, 33);
    idle_chk("b2b");
    repeat (3) @(negedge clk_i);
    chk("b2b_pulses", 32'(done_cnt - d0), 32'd2);

    // reset while cnt==10
    @(negedge clk_i);
    req_i = 1'b1;
    funct_i = {7'b0000001, 3'b000};
    rs1_data_i = 32'd9;
    rs2_data_i = 32'd9;
    d0 = done_cnt;
    repeat (11) @(negedge clk_i);
    #1;
    chk("mid_stall_pre", 32'(stall_o), 32'd1);
    chk("mid_cnt", 32'(dut.cnt_q), 32'd10);
    rst_i = 1'b1;
    req_i = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("mid_post_stall", 32'(stall_o), 32'd0);
    chk("mid_post_res", result_o, 32'd0);
    repeat (40) @(negedge clk_i);
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    do_op("mul_after", 3'b000, 32'd6, 32'd7, 32'd42, 33);
    idle_chk("mul_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
